// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for a runtime-programmed rate k/n trellis.
// Survivors use register exchange, so the result is available as soon as the last step is taken.
module viterbi_decoder #(
  parameter int n = 2,
  parameter int k = 1,
  parameter int m = 4,
  parameter int L = 7,
  parameter int E = $clog2(L * n)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  input  logic           enable,
  input  logic [0:n-1]   encoded,
  output logic [0:k*L-1] decoded,
  output logic [E:0]     error,
  output logic           ready,
  input  logic           load,
  input  logic [0:m-k-1] state_address,
  input  logic [0:k-1]   input_address,
  input  logic [0:m-k-1] next_state_data,
  input  logic [0:n-1]   output_data
);

  localparam int S   = m - k;
  localparam int NST = 1 << S;
  localparam int NIN = 1 << k;
  localparam int KL  = k * L;
  localparam int CW  = (L > 1) ? $clog2(L) : 1;
  localparam int PW  = (KL > 1) ? $clog2(KL) : 1;
  localparam int MW  = E + 1;

  logic [S-1:0]   ns_q      [NST][NIN];
  logic [S-1:0]   ns_d      [NST][NIN];
  logic [n-1:0]   out_q     [NST][NIN];
  logic [n-1:0]   out_d     [NST][NIN];
  logic [MW-1:0]  metric_q  [NST];
  logic [MW-1:0]  metric_d  [NST];
  logic [0:KL-1]  path_q    [NST];
  logic [0:KL-1]  path_d    [NST];
  logic [NST-1:0] valid_q, valid_d;
  logic [CW-1:0]  step_q, step_d;
  logic           ready_q, ready_d;
  logic [0:KL-1]  decoded_q, decoded_d;
  logic [MW-1:0]  error_q, error_d;

  logic [MW-1:0]  acs_metric_s [NST];
  logic [0:KL-1]  acs_path_s   [NST];
  logic [NST-1:0] acs_valid_s;
  logic [MW-1:0]  cand_s;
  logic [PW-1:0]  slot_s;
  logic           best_valid_s;
  logic [MW-1:0]  best_metric_s;
  logic [0:KL-1]  best_path_s;

  function automatic logic [MW-1:0] popcount(input logic [n-1:0] v);
    logic [MW-1:0] c;
    c = '0;
    for (int i = 0; i < n; i++) begin
      c = c + MW'(v[i]);
    end
    return c;
  endfunction

  // Add-compare-select: each target keeps its cheapest predecessor, scanning {s,u} upward so ties keep the lowest.
  always_comb begin
    cand_s      = '0;
    slot_s      = PW'(k * int'(step_q));
    acs_valid_s = '0;
    for (int t = 0; t < NST; t++) begin
      acs_metric_s[t] = '0;
      acs_path_s[t]   = '0;
      for (int s = 0; s < NST; s++) begin
        for (int u = 0; u < NIN; u++) begin
          cand_s = metric_q[s] + popcount(encoded ^ out_q[s][u]);
          if (valid_q[s] && (ns_q[s][u] == S'(t)) &&
              (!acs_valid_s[t] || (cand_s < acs_metric_s[t]))) begin
            acs_valid_s[t]                = 1'b1;
            acs_metric_s[t]               = cand_s;
            acs_path_s[t]                 = path_q[s];
            acs_path_s[t][slot_s +: k]    = k'(u);
          end
        end
      end
    end
  end

  // Pick the best survivor of the step being taken, lowest state index on ties.
  always_comb begin
    best_valid_s  = 1'b0;
    best_metric_s = '0;
    best_path_s   = '0;
    for (int t = 0; t < NST; t++) begin
      if (acs_valid_s[t] && (!best_valid_s || (acs_metric_s[t] < best_metric_s))) begin
        best_valid_s  = 1'b1;
        best_metric_s = acs_metric_s[t];
        best_path_s   = acs_path_s[t];
      end
    end
  end

  // Next-state control: table writes, frame restart, and decode steps.
  always_comb begin
    ns_d      = ns_q;
    out_d     = out_q;
    metric_d  = metric_q;
    path_d    = path_q;
    valid_d   = valid_q;
    step_d    = step_q;
    ready_d   = ready_q;
    decoded_d = decoded_q;
    error_d   = error_q;
    if (load) begin
      ns_d[state_address][input_address]  = next_state_data;
      out_d[state_address][input_address] = output_data;
    end else begin
      ns_d = ns_q;
    end
    if (restart) begin
      for (int s = 0; s < NST; s++) begin
        metric_d[s] = '0;
        path_d[s]   = '0;
      end
      valid_d   = NST'(1);
      step_d    = '0;
      ready_d   = 1'b0;
      decoded_d = '0;
      error_d   = '0;
    end else if (enable && !load && !ready_q) begin
      metric_d = acs_metric_s;
      path_d   = acs_path_s;
      valid_d  = acs_valid_s;
      // The final step publishes the winner directly, so no traceback cycle follows.
      if (step_q == CW'(L - 1)) begin
        ready_d   = 1'b1;
        decoded_d = best_path_s;
        error_d   = best_metric_s;
      end else begin
        step_d = step_q + CW'(1);
      end
    end else begin
      step_d = step_q;
    end
  end

  // State registers; reset also wipes the trellis tables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NST; s++) begin
        for (int u = 0; u < NIN; u++) begin
          ns_q[s][u]  <= '0;
          out_q[s][u] <= '0;
        end
        metric_q[s] <= '0;
        path_q[s]   <= '0;
      end
      valid_q   <= NST'(1);
      step_q    <= '0;
      ready_q   <= 1'b0;
      decoded_q <= '0;
      error_q   <= '0;
    end else begin
      ns_q      <= ns_d;
      out_q     <= out_d;
      metric_q  <= metric_d;
      path_q    <= path_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      ready_q   <= ready_d;
      decoded_q <= decoded_d;
      error_q   <= error_d;
    end
  end

  assign decoded = decoded_q;
  assign error   = error_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder with the K=4 trellis.
// Random frames are checked against an array-based Viterbi model and a brute-force ML search.
module tb_viterbi_decoder;

  localparam int N = 2;
  localparam int K = 1;
  localparam int M = 4;
  localparam int L = 7;
  localparam int E = 4;
  localparam int INF = 1000;
  localparam logic [0:6] T1_DEC = 7'b1011000;

  logic             clk = 1'b0;
  logic             reset;
  logic             restart;
  logic             enable;
  logic [0:N-1]     encoded;
  logic [0:K*L-1]   decoded;
  logic [E:0]       error;
  logic             ready;
  logic             load;
  logic [0:M-K-1]   state_address;
  logic [0:K-1]     input_address;
  logic [0:M-K-1]   next_state_data;
  logic [0:N-1]     output_data;

  int checks = 0;
  int errors = 0;

  int tab_ns  [16] = '{0, 4, 0, 4, 1, 5, 1, 5, 2, 6, 2, 6, 3, 7, 3, 7};
  int tab_out [16] = '{0, 3, 3, 0, 2, 1, 1, 2, 3, 0, 0, 3, 1, 2, 2, 1};
  logic [1:0] t1_frame [7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
  logic [1:0] t2_frame [7] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};

  logic [1:0] frm [7];
  logic [0:6] model_dec;
  int         model_err;
  int         brute_err;

  viterbi_decoder #(.n(N), .k(K), .m(M), .L(L)) dut (
    .clk(clk), .reset(reset), .restart(restart), .enable(enable),
    .encoded(encoded), .decoded(decoded), .error(error), .ready(ready),
    .load(load), .state_address(state_address), .input_address(input_address),
    .next_state_data(next_state_data), .output_data(output_data)
  );

  always #5 clk = ~clk;

  // Viterbi over plain int arrays plus an exhaustive search for the minimum distance.
  task automatic run_model();
    int met [8];
    int nmet [8];
    logic [0:6] pth [8];
    logic [0:6] npth [8];
    int c, t, st, d;
    for (int s = 0; s < 8; s++) begin
      met[s] = (s == 0) ? 0 : INF;
      pth[s] = '0;
    end
    for (int i = 0; i < 7; i++) begin
      for (int s = 0; s < 8; s++) begin
        nmet[s] = INF;
        npth[s] = '0;
      end
      for (int s = 0; s < 8; s++) begin
        for (int u = 0; u < 2; u++) begin
          if (met[s] < INF) begin
            c = met[s] + $countones(frm[i] ^ 2'(tab_out[s*2+u]));
            t = tab_ns[s*2+u];
            if (c < nmet[t]) begin
              nmet[t] = c;
              npth[t] = pth[s];
              npth[t][i] = 1'(u);
            end
          end
        end
      end
      met = nmet;
      pth = npth;
    end
    model_err = INF;
    model_dec = '0;
    for (int s = 0; s < 8; s++) begin
      if (met[s] < model_err) begin
        model_err = met[s];
        model_dec = pth[s];
      end
    end
    brute_err = INF;
    for (int x = 0; x < 128; x++) begin
      st = 0;
      d  = 0;
      for (int i = 0; i < 7; i++) begin
        c  = (x >> (6 - i)) & 1;
        d  = d + $countones(frm[i] ^ 2'(tab_out[st*2+c]));
        st = tab_ns[st*2+c];
      end
      if (d < brute_err) brute_err = d;
    end
  endtask

  task automatic send(input logic [1:0] e);
    @(negedge clk);
    load = 1'b0; restart = 1'b0; enable = 1'b1; encoded = e;
  endtask

  task automatic pause();
    @(negedge clk);
    load = 1'b0; restart = 1'b0; enable = 1'b0; encoded = 2'($urandom_range(0, 3));
  endtask

  task automatic do_restart();
    @(negedge clk);
    load = 1'b0; enable = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      enable = 1'b0; restart = 1'b0; load = 1'b1;
      state_address   = 3'(i / 2);
      input_address   = 1'(i % 2);
      next_state_data = 3'(tab_ns[i]);
      output_data     = 2'(tab_out[i]);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; enable = 1'b0; load = 1'b0; encoded = '0;
    state_address = '0; input_address = '0; next_state_data = '0; output_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (decoded !== 7'd0) begin errors++; $display("FAIL reset_decoded: got %b expected 0000000", decoded); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL reset_error: got %0d expected 0", error); end
  endtask

  task automatic test_t1();
    load_table();
    for (int i = 0; i < 7; i++) send(t1_frame[i]);
    pause();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t1_ready: got %b expected 1", ready); end
    checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t1_decoded: got %b expected %b", decoded, T1_DEC); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t1_error: got %0d expected 0", error); end
  endtask

  task automatic test_t2();
    do_restart();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t2_restart_ready: got %b expected 0", ready); end
    for (int i = 0; i < 7; i++) send(t2_frame[i]);
    pause();
    checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t2_decoded: got %b expected %b", decoded, T1_DEC); end
    checks++; if (error !== 5'd1) begin errors++; $display("FAIL t2_error: got %0d expected 1", error); end
  endtask

  task automatic test_pause();
    do_restart();
    for (int i = 0; i < 6; i++) send(t1_frame[i]);
    pause();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t3_ready_after6: got %b expected 0", ready); end
    pause();
    pause();
    send(t1_frame[6]);
    pause();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t3_ready: got %b expected 1", ready); end
    checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t3_decoded: got %b expected %b", decoded, T1_DEC); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t3_error: got %0d expected 0", error); end
  endtask

  task automatic test_restart_mid();
    do_restart();
    for (int i = 0; i < 3; i++) send(t2_frame[i]);
    do_restart();
    for (int i = 0; i < 7; i++) send(t1_frame[i]);
    pause();
    checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t4_decoded: got %b expected %b", decoded, T1_DEC); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t4_error: got %0d expected 0", error); end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 4; c++) begin
      send(2'($urandom_range(0, 3)));
      @(posedge clk);
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t5_ready: got %b expected 1", ready); end
      checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t5_decoded: got %b expected %b", decoded, T1_DEC); end
      checks++; if (error !== 5'd0) begin errors++; $display("FAIL t5_error: got %0d expected 0", error); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      do_restart();
      for (int i = 0; i < 7; i++) begin
        frm[i] = 2'($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) pause();
        send(frm[i]);
        if (i == 5) begin
          pause();
          checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rand_ready_early: frame %0d got %b expected 0", f, ready); end
        end
      end
      pause();
      run_model();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rand_ready: frame %0d got %b expected 1", f, ready); end
      checks++; if (decoded !== model_dec) begin errors++; $display("FAIL rand_decoded: frame %0d got %b expected %b", f, decoded, model_dec); end
      checks++; if (int'(error) != model_err) begin errors++; $display("FAIL rand_error: frame %0d got %0d expected %0d", f, error, model_err); end
      checks++; if (int'(error) != brute_err) begin errors++; $display("FAIL rand_ml_distance: frame %0d got %0d expected %0d", f, error, brute_err); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t6_async_ready: got %b expected 0", ready); end
    checks++; if (decoded !== 7'd0) begin errors++; $display("FAIL t6_async_decoded: got %b expected 0000000", decoded); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t6_async_error: got %0d expected 0", error); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) send(t1_frame[i]);
    pause();
    checks++; if (decoded !== 7'd0) begin errors++; $display("FAIL t6_cleared_decoded: got %b expected 0000000", decoded); end
    checks++; if (error !== 5'd11) begin errors++; $display("FAIL t6_cleared_error: got %0d expected 11", error); end
    do_restart();
    for (int i = 0; i < 3; i++) send(t1_frame[i]);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t6_mid_ready: got %b expected 0", ready); end
    checks++; if (decoded !== 7'd0) begin errors++; $display("FAIL t6_mid_decoded: got %b expected 0000000", decoded); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t6_mid_error: got %0d expected 0", error); end
    @(negedge clk);
    reset = 1'b0;
    load_table();
    for (int i = 0; i < 7; i++) send(t1_frame[i]);
    pause();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t6_rerun_ready: got %b expected 1", ready); end
    checks++; if (decoded !== T1_DEC) begin errors++; $display("FAIL t6_rerun_decoded: got %b expected %b", decoded, T1_DEC); end
    checks++; if (error !== 5'd0) begin errors++; $display("FAIL t6_rerun_error: got %0d expected 0", error); end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_t2();
    test_pause();
    test_restart_mid();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
